// File: rtl/deser_stream_if.sv
// Handshake bundle for deser_stream: serial beat input side and assembled word output side.
// The slave modport is the deserializer's view and the master modport is the driver's view.
interface deser_stream_if #(
    parameter int DESER_W = 16,
    parameter int IN_W    = 1,
    parameter int LEN_W   = $clog2(DESER_W + 1)
);
    logic [IN_W-1:0]    data_i;
    logic               data_val_i;
    logic               data_last_i;
    logic               data_rdy_o;
    logic [DESER_W-1:0] deser_data_o;
    logic [LEN_W-1:0]   deser_len_o;
    logic               deser_data_val_o;
    logic               deser_data_rdy_i;

    modport slave (
        input  data_i, data_val_i, data_last_i, deser_data_rdy_i,
        output data_rdy_o, deser_data_o, deser_len_o, deser_data_val_o
    );

    modport master (
        output data_i, data_val_i, data_last_i, deser_data_rdy_i,
        input  data_rdy_o, deser_data_o, deser_len_o, deser_data_val_o
    );
endinterface

// File: rtl/deser_stream.sv
// Packs IN_W-bit beats into DESER_W-bit words with early close on data_last_i.
// The output word register doubles as a one-entry buffer that applies backpressure.
module deser_stream #(
    parameter int DESER_W   = 16,
    parameter int IN_W      = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk_i,
    input  logic          arst_n_i,
    deser_stream_if.slave bus
);
    localparam int BEATS = DESER_W / IN_W;
    localparam int LEN_W = $clog2(DESER_W + 1);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DESER_W-1:0] acc_q, acc_d;
    logic [DESER_W-1:0] word_q, word_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               val_q, val_d;

    logic               slotFree;
    logic               accept;
    logic               completing;
    logic [DESER_W-1:0] beatWord;
    logic [LEN_W-1:0]   lenNext;

    assign slotFree   = !val_q || bus.deser_data_rdy_i;
    assign accept     = bus.data_val_i && slotFree;
    assign completing = accept && ((cnt_q == CNT_W'(BEATS - 1)) || bus.data_last_i);
    assign lenNext    = LEN_W'((int'(cnt_q) + 1) * IN_W);

    // Place the incoming beat into its slot; every other bit stays zero.
    always_comb begin
        beatWord = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                if (MSB_FIRST) begin
                    beatWord[DESER_W-1-k*IN_W -: IN_W] = bus.data_i;
                end else begin
                    beatWord[k*IN_W +: IN_W] = bus.data_i;
                end
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        word_d = word_q;
        len_d  = len_q;
        val_d  = val_q;
        if (completing) begin
            word_d = acc_q | beatWord;
            len_d  = lenNext;
            val_d  = 1'b1;
            cnt_d  = '0;
            acc_d  = '0;
        end else begin
            if (accept) begin
                cnt_d = cnt_q + 1'b1;
                acc_d = acc_q | beatWord;
            end
            if (val_q && bus.deser_data_rdy_i) begin
                val_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            word_q <= '0;
            len_q  <= '0;
            val_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            word_q <= word_d;
            len_q  <= len_d;
            val_q  <= val_d;
        end
    end

    assign bus.data_rdy_o       = slotFree;
    assign bus.deser_data_o     = word_q;
    assign bus.deser_len_o      = len_q;
    assign bus.deser_data_val_o = val_q;
endmodule
